mano_io_unit: RTL

- Peripheral at the far end of the basic computer's I/O instructions (INP, OUT, SKI, SKO, ION, IOF).
- The CPU-side port exposes INPR/FGI, OUTR/FGO and IEN, and raises the interrupt request that sets R.
- The device-side port moves bytes in and out with valid/ready handshakes.
- A small input FIFO absorbs device bursts while the CPU is mid-instruction.

---
 rtl/mano_io_pkg.sv | 15 +
 rtl/mano_io_fifo.sv | 63 ++++++
 rtl/mano_io_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mano_io_pkg.sv
// Shared defaults and derived widths for the Mano basic-computer I/O unit.
// Optional loopback path is enabled by defining MANO_IO_LOOPBACK_EN.
package mano_io_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int PTR_W          = $clog2(FIFO_DEPTH_DEF);
    localparam int CNT_W          = PTR_W + 1;

    // Occupancy counter width for an arbitrary power-of-two depth
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mano_io_fifo.sv
// Small synchronous FIFO buffering device bytes ahead of INPR.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module mano_io_fifo
    import mano_io_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = cnt_width(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mano_io_unit.sv
// Mano basic-computer I/O unit: INPR/FGI, OUTR/FGO, IEN and the interrupt
// request, with a device-side FIFO in front of INPR.
// Defining MANO_IO_LOOPBACK_EN adds lb_en, which routes OUTR into the FIFO.
module mano_io_unit
    import mano_io_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MANO_IO_LOOPBACK_EN
    input  logic              lb_en,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              inp_rd,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_wdata,
    output logic              fgo,
    input  logic              ien_set,
    input  logic              ien_clr,
    input  logic              irq_ack,
    output logic              ien,
    output logic              irq
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    logic              lb;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] push_data;
    logic              push;
    logic              pop;
    logic              ov_q;
    logic              out_hs;

`ifdef MANO_IO_LOOPBACK_EN
    assign lb = lb_en;
`else
    assign lb = 1'b0;
`endif

    // In loopback the pending OUTR byte is the FIFO source and the device side is muted
    assign in_ready  = !rst && !fifo_full && !lb;
    assign push      = lb ? (ov_q && !fifo_full) : (in_valid && in_ready);
    assign push_data = lb ? out_data : in_data;
    assign out_hs    = ov_q && (lb ? !fifo_full : out_ready);
    assign out_valid = ov_q && !lb;
    assign pop       = !fgi && !fifo_empty;

    mano_io_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Consistency check between the FIFO's full flag and its count; ignored by synthesis
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
        end
    end

    // INPR/FGI: a read clears FGI, the refill from the FIFO waits for the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            inpr <= '0;
            fgi  <= 1'b0;
        end else if (fgi && inp_rd) begin
            fgi <= 1'b0;
        end else if (pop) begin
            inpr <= fifo_head;
            fgi  <= 1'b1;
        end
    end

    // OUTR/FGO: handshake frees OUTR; writes only land when FGO was already set
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            ov_q     <= 1'b0;
            fgo      <= 1'b1;
        end else if (out_hs) begin
            ov_q <= 1'b0;
            fgo  <= 1'b1;
        end else if (out_wr && fgo) begin
            out_data <= out_wdata;
            ov_q     <= 1'b1;
            fgo      <= 1'b0;
        end
    end

    // IEN and the registered interrupt request; clears win over ION
    always_ff @(posedge clk) begin
        if (rst) begin
            ien <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (irq_ack || ien_clr) begin
                ien <= 1'b0;
            end else if (ien_set) begin
                ien <= 1'b1;
            end
            irq <= !irq_ack && ien && (fgi || fgo);
        end
    end

endmodule
